// File: rtl/stream_interface_m.sv
// rtl/stream_interface_m.sv - BRAM-pair reader that streams read instructions out as AXI-stream beats
// Credit-gated read issue, RD_LAT tag pipeline and a first-word-fall-through output FIFO.
module stream_interface_m #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  s_instruct_tdata,
  input  logic         s_instruct_tvalid,
  output logic         s_instruct_tready,
  output logic [127:0] m_out_tdata,
  output logic         m_out_tvalid,
  input  logic         m_out_tready,
  output logic [15:0]  m_out_tkeep,
  output logic         m_out_tlast,
  output logic [13:0]  addr_l,
  output logic         en_l,
  input  logic [127:0] dout_l,
  output logic [13:0]  addr_h,
  output logic         en_h,
  input  logic [127:0] dout_h,
  output logic         busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [13:0]   rd_addr, addr_l_q, addr_h_q;
  logic [15:0]   len_q, issued;
  logic          bank_q, ilv_q;
  logic [CW-1:0] committed;
  logic          accept, issue, issue_bank, issue_last, pop;

  logic [RD_LAT-1:0] tag_v, tag_b, tag_l;
  logic              push;
  logic [127:0]      push_data;

  logic [127:0]          fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_cnt;

  logic unused_hi;
  assign unused_hi = ^s_instruct_tdata[63:32];

  assign s_instruct_tready = (state == IDLE) & ~rst;
  assign accept            = s_instruct_tvalid & s_instruct_tready;

  // committed counts FIFO entries plus reads in flight; a free slot is the credit
  assign issue      = (state == ISSUE) && (committed != CW'(FIFO_DEPTH));
  assign issue_bank = ilv_q ? issued[0] : bank_q;
  assign issue_last = (issued == len_q - 16'd1);

  assign en_l   = issue & ~issue_bank;
  assign en_h   = issue & issue_bank;
  assign addr_l = en_l ? rd_addr : addr_l_q;
  assign addr_h = en_h ? rd_addr : addr_h_q;

  assign m_out_tvalid = (fifo_cnt != '0);
  assign m_out_tdata  = m_out_tvalid ? fifo_data[rd_ptr] : '0;
  assign m_out_tlast  = m_out_tvalid & fifo_last[rd_ptr];
  assign m_out_tkeep  = '1;
  assign pop          = m_out_tvalid & m_out_tready;
  assign busy         = (state != IDLE) | m_out_tvalid;

  assign push      = tag_v[RD_LAT-1];
  assign push_data = tag_b[RD_LAT-1] ? dout_h : dout_l;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && s_instruct_tdata[29:14] != 16'd0) state_nxt = ISSUE;
      ISSUE:   if (issue && issue_last) state_nxt = DRAIN;
      DRAIN:   if (pop && m_out_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_addr  <= '0;
      addr_l_q <= '0;
      addr_h_q <= '0;
      len_q    <= '0;
      issued   <= '0;
      bank_q   <= 1'b0;
      ilv_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_addr <= s_instruct_tdata[13:0];
        len_q   <= s_instruct_tdata[29:14];
        bank_q  <= s_instruct_tdata[30];
        ilv_q   <= s_instruct_tdata[31];
        issued  <= '0;
      end
      if (issue) begin
        issued <= issued + 16'd1;
        // interleaved pairs share one address: advance after the high-bank read
        if (!ilv_q || issued[0]) rd_addr <= rd_addr + 14'd1;
        if (en_l) addr_l_q <= rd_addr;
        if (en_h) addr_h_q <= rd_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      committed <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   committed <= committed + CW'(1);
        2'b01:   committed <= committed - CW'(1);
        default: committed <= committed;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      tag_b <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= issue;
      tag_b[0] <= issue_bank;
      tag_l[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_b[i] <= tag_b[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_last[wr_ptr] <= tag_l[RD_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && fifo_cnt == CW'(FIFO_DEPTH)));
  end

endmodule

// File: tb/tb_stream_interface_m.sv
// tb/tb_stream_interface_m.sv - table-driven scoreboard bench for stream_interface_m
module tb_stream_interface_m;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  s_instruct_tdata;
  logic         s_instruct_tvalid, s_instruct_tready;
  logic [127:0] m_out_tdata;
  logic         m_out_tvalid, m_out_tready, m_out_tlast;
  logic [15:0]  m_out_tkeep;
  logic [13:0]  addr_l, addr_h;
  logic         en_l, en_h, busy;
  logic [127:0] dout_l, dout_h, p_l, p_h;

  always #5 clk = ~clk;

  stream_interface_m #(.RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_instruct_tdata(s_instruct_tdata), .s_instruct_tvalid(s_instruct_tvalid),
    .s_instruct_tready(s_instruct_tready),
    .m_out_tdata(m_out_tdata), .m_out_tvalid(m_out_tvalid), .m_out_tready(m_out_tready),
    .m_out_tkeep(m_out_tkeep), .m_out_tlast(m_out_tlast),
    .addr_l(addr_l), .en_l(en_l), .dout_l(dout_l),
    .addr_h(addr_h), .en_h(en_h), .dout_h(dout_h),
    .busy(busy)
  );

  function automatic logic [127:0] word(input logic b, input logic [13:0] a);
    logic [31:0] x;
    x = {17'h0, b, a};
    return {x ^ 32'hA5C3_0000, x * 32'h9E37_79B1, ~x, (b ? 16'hB00B : 16'h1EAF), 2'b00, a};
  endfunction

  // two-stage BRAM model: data for an en/addr cycle appears RD_LAT=2 cycles later
  always @(posedge clk) begin
    if (en_l) p_l <= word(1'b0, addr_l);
    if (en_h) p_h <= word(1'b1, addr_h);
    dout_l <= p_l;
    dout_h <= p_h;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] start;
    logic [15:0] len;
    logic        bank;
    logic        ilv;
    logic        rnd;
    int          exp_first;
    int          exp_last;
  } vec_t;

  vec_t vecs[7];
  logic [14:0]  exp_addr[$];
  logic [128:0] exp_data[$];
  int checks, errors, beat_cnt, first_v, last_c, out_cnt;
  logic saw_full, rnd_mode;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      m_out_tready = rnd_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  endtask

  task automatic monitor();
    logic pv, pl;
    logic [127:0] pd;
    logic [14:0] ea;
    logic [128:0] ed;
    logic hs;
    pv = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_addr.delete();
        exp_data.delete();
        out_cnt = 0;
        pv = 1'b0;
      end else begin
        hs = m_out_tvalid & m_out_tready;
        if (en_l || en_h) begin
          chk("en_exclusive", en_l & en_h, 0);
          if (exp_addr.size() == 0) chk("unexpected_read", 1, 0);
          else begin
            ea = exp_addr.pop_front();
            chk("read_bank_addr", {en_h, en_h ? addr_h : addr_l}, ea);
          end
        end
        if (en_l || en_h || hs) begin
          out_cnt = out_cnt + int'(en_l | en_h) - int'(hs);
          if (out_cnt == DEPTH) saw_full = 1'b1;
          chk("occupancy_le_depth", out_cnt <= DEPTH, 1);
        end
        if (pv) begin
          chk("hold_valid", m_out_tvalid, 1);
          chk("hold_data", m_out_tdata, pd);
          chk("hold_last", m_out_tlast, pl);
        end
        if (m_out_tvalid && first_v < 0) first_v = cyc;
        if (hs) begin
          beat_cnt++;
          if (exp_data.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            ed = exp_data.pop_front();
            chk("beat_data", m_out_tdata, ed[127:0]);
            chk("beat_last", m_out_tlast, ed[128]);
          end
          if (m_out_tlast) last_c = cyc;
        end
        pv = m_out_tvalid & ~m_out_tready;
        pd = m_out_tdata;
        pl = m_out_tlast;
      end
    end
  endtask

  task automatic send(input logic [13:0] start, input logic [15:0] len, input logic bank,
                      input logic ilv, output int t, output int waited);
    logic b;
    logic [13:0] a;
    for (int k = 0; k < int'(len); k++) begin
      b = ilv ? k[0] : bank;
      a = start + 14'(ilv ? (k >> 1) : k);
      exp_addr.push_back({b, a});
      exp_data.push_back({(k == int'(len) - 1), word(b, a)});
    end
    first_v = -1; last_c = -1; beat_cnt = 0; waited = 0;
    s_instruct_tdata  = {32'hCAFE_F00D, ilv, bank, len, start};
    s_instruct_tvalid = 1'b1;
    @(negedge clk);
    while (!s_instruct_tready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    t = cyc;
    @(posedge clk);
    #1;
    s_instruct_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_data.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 3000, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, w, n;
    vec_t v;
    rst = 1'b1; s_instruct_tvalid = 1'b0; s_instruct_tdata = '0;
    m_out_tready = 1'b1; rnd_mode = 1'b0; saw_full = 1'b0;
    checks = 0; errors = 0; beat_cnt = 0; first_v = -1; last_c = -1; out_cnt = 0;
    vecs[0] = '{14'h0010, 16'd4,  1'b0, 1'b0, 1'b0,  4,  7};
    vecs[1] = '{14'h3FFE, 16'd4,  1'b1, 1'b0, 1'b0,  4,  7};
    vecs[2] = '{14'h0100, 16'd5,  1'b0, 1'b1, 1'b0,  4,  8};
    vecs[3] = '{14'h0200, 16'd64, 1'b0, 1'b0, 1'b1,  4, -1};
    vecs[4] = '{14'h0000, 16'd0,  1'b0, 1'b0, 1'b0, -1, -1};
    vecs[5] = '{14'h0300, 16'd1,  1'b1, 1'b0, 1'b0,  4,  4};
    vecs[6] = '{14'h3FFD, 16'd7,  1'b1, 1'b1, 1'b0,  4, 10};
    fork
      monitor();
      ready_drv();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", s_instruct_tready, 0);
    chk("rst_tvalid", m_out_tvalid, 0);
    chk("rst_tlast", m_out_tlast, 0);
    chk("rst_tdata", m_out_tdata, 0);
    chk("rst_en", {en_l, en_h}, 0);
    chk("rst_addr", {addr_l, addr_h}, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      rnd_mode = v.rnd;
      saw_full = 1'b0;
      send(v.start, v.len, v.bank, v.ilv, t, w);
      wait_idle();
      rnd_mode = 1'b0;
      chk("accept_wait", w, 0);
      chk("beat_count", beat_cnt, 32'(v.len));
      chk("first_valid_lat", (first_v < 0) ? -1 : first_v - t, v.exp_first);
      if (!v.rnd) chk("tlast_lat", (last_c < 0) ? -1 : last_c - t, v.exp_last);
      else chk("credit_reached_zero", saw_full, 1);
      chk("reads_consumed", exp_addr.size(), 0);
      chk("tkeep", m_out_tkeep, 16'hFFFF);
      @(negedge clk);
      chk("idle_tready", s_instruct_tready, 1);
      @(posedge clk);
      #1;
    end

    send(14'h0400, 16'd32, 1'b0, 1'b0, t, w);
    n = 0;
    while (beat_cnt < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_10_beats", beat_cnt >= 10, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tvalid", m_out_tvalid, 0);
    chk("abort_en", {en_l, en_h}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_tready", s_instruct_tready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", s_instruct_tready, 1);
    @(posedge clk);
    #1;
    send(14'h0500, 16'd2, 1'b1, 1'b0, t, w);
    wait_idle();
    chk("post_rst_beats", beat_cnt, 2);
    chk("post_rst_tlast_lat", last_c - t, RD_LAT + 1 + 2);
    repeat (4) @(negedge clk);
    chk("post_rst_quiet", {m_out_tvalid, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
